// File: rtl/xor_parity_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_sched_if
// Description : Requester-side bundle for the shared bit-serial XOR/XNOR
//               reduction engine. Carries two request/grant/done channels
//               plus the engine busy flag.
//   req0/1    : request level, held by the requester until its grant
//   data0/1   : operand, sampled by the engine on the grant edge
//   mode0/1   : 0 = XOR reduction, 1 = XNOR reduction
//   gnt0/1    : one-cycle grant pulse
//   done0/1   : one-cycle completion pulse
//   result0/1 : reduction result, held until the next completion
//   busy      : engine is processing an operand
//   modport master : requester side; modport slave : engine side
// Revision    : 1.0 - initial release
// ============================================================================
interface xor_parity_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             mode0;
    logic             gnt0;
    logic             done0;
    logic             result0;

    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             mode1;
    logic             gnt1;
    logic             done1;
    logic             result1;

    logic             busy;

    modport master (
        output req0, data0, mode0, req1, data1, mode1,
        input  gnt0, done0, result0, gnt1, done1, result1, busy
    );

    modport slave (
        input  req0, data0, mode0, req1, data1, mode1,
        output gnt0, done0, result0, gnt1, done1, result1, busy
    );
endinterface
`default_nettype wire

// File: rtl/xor_parity_sched.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_sched
// Description : Round-robin arbitrated, bit-serial XOR/XNOR reduction engine
//               shared by two requesters. One operand bit is folded into a
//               single-bit accumulator per clock, so an operation takes
//               WIDTH cycles after its grant edge.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - requester channels (xor_parity_sched_if.slave)
// Parameters  : WIDTH - operand width (2..32)
//               CW    - bit-counter width, 2**CW >= WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module xor_parity_sched #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    xor_parity_sched_if.slave      bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic             r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_op_mode;
    logic             r_owner;
    logic             r_last_served;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic             r_result0;
    logic             r_result1;
    logic             r_busy;

    logic             w_any_req;
    logic             w_pick1;

    // Requester 1 wins when it is alone, or when both ask and requester 0
    // was the most recently served.
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_pick1   = bus.req1 & (~bus.req0 | ~r_last_served);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sreg        <= '0;
            r_acc         <= 1'b0;
            r_cnt         <= '0;
            r_op_mode     <= 1'b0;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_result0     <= 1'b0;
            r_result1     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        if (w_pick1) begin
                            r_gnt1    <= 1'b1;
                            r_sreg    <= bus.data1;
                            r_op_mode <= bus.mode1;
                        end else begin
                            r_gnt0    <= 1'b1;
                            r_sreg    <= bus.data0;
                            r_op_mode <= bus.mode0;
                        end
                        r_acc         <= 1'b0;
                        r_cnt         <= '0;
                        r_owner       <= w_pick1;
                        r_last_served <= w_pick1;
                        r_busy        <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_acc  <= r_acc ^ r_sreg[0];
                    r_sreg <= r_sreg >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    // The last bit is still in sreg[0] on the final edge, so
                    // it is folded directly into the published result.
                    if (r_cnt == c_last_bit) begin
                        if (r_owner) begin
                            r_result1 <= r_acc ^ r_sreg[0] ^ r_op_mode;
                            r_done1   <= 1'b1;
                        end else begin
                            r_result0 <= r_acc ^ r_sreg[0] ^ r_op_mode;
                            r_done0   <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;
    assign bus.result0 = r_result0;
    assign bus.result1 = r_result1;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire
